// File: rtl/countdown_timer_nd.sv
// BCD countdown timer with run/pause/done FSM and multiplexed seven-segment scan outputs.
// Define TIMER_AUTO_RELOAD_EN to reload the last captured preset and keep running after zero.
module countdown_timer_nd #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_pause,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [1:0]              state,
  output logic                    done,
  output logic [15:0]             led,
  output logic [NUM_DIGITS-1:0]   ssd_ctl,
  output logic [3:0]              ssd_in
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   count_q, count_d;
  logic [DW-1:0]   count_dec, preset_clamped;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic            tick, capture, borrow, count_dec_zero;

  always_comb begin
    preset_clamped = preset;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) preset_clamped[4*i +: 4] = 4'd9;
    end
  end

  // Ripple BCD borrow: a zero digit becomes 9 and passes the borrow upward.
  always_comb begin
    count_dec = count_q;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_dec_zero = (count_dec == '0);
  assign tick           = (state_q == StRun) && (presc_q == PW'(TICK_DIV - 1));
  assign capture        = load && (state_q != StRun);

`ifdef TIMER_AUTO_RELOAD_EN
  logic [DW-1:0] reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else if (capture) begin
      reload_q <= preset_clamped;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = '0;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          count_d = preset_clamped;
        end else if (start_pause && (count_q != '0)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && (count_q != '0)) count_d = count_dec;
        if (tick && (count_q != '0) && count_dec_zero) begin
          state_d = StDone;
        end else if (start_pause) begin
          state_d = StPause;
        end
      end
      StPause: begin
        presc_d = presc_q;
        if (capture) begin
          count_d = preset_clamped;
          state_d = StIdle;
        end else if (start_pause) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (capture) begin
          count_d = preset_clamped;
          state_d = StIdle;
`ifdef TIMER_AUTO_RELOAD_EN
        end else if (reload_q != '0) begin
          count_d = reload_q;
          state_d = StRun;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign bcd_out = count_q;
  assign state   = state_q;
  assign done    = (state_q == StDone);
  assign led     = {16{done}};

  always_comb begin
    ssd_ctl = '1;
    ssd_in  = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        ssd_ctl[i] = 1'b0;
        ssd_in     = count_q[4*i +: 4];
      end
    end
  end

endmodule

// File: doc/countdown_timer_nd.md
COUNTDOWN_TIMER_ND -- requirements
Module: countdown_timer_nd

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits, 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 100000000: clk cycles per count tick, >=2.
REQ-003 SHALL have parameter SCAN_DIV, default 100000: clk cycles per display-scan step, >=2.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_pause  input  1  single-cycle pulse (pre-debounced); toggles run/pause.
REQ-007 SHALL have port load  input  1  single-cycle pulse; loads preset.
REQ-008 SHALL have port preset  input  4*NUM_DIGITS  BCD start value; digit 0 in bits [3:0].
REQ-009 SHALL have port bcd_out  output  4*NUM_DIGITS  current count, BCD.
REQ-010 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port led  output  16  all ones in DONE, else all zeros.
REQ-013 SHALL have port ssd_ctl  output  NUM_DIGITS  one-hot active-low digit enable.
REQ-014 SHALL have port ssd_in  output  4  BCD of the digit currently enabled.

Function
REQ-015 SHALL implement FSM IDLE/RUN/PAUSE/DONE, registered, transitions one cycle after the triggering input.
REQ-016 SHALL, on load in IDLE, PAUSE or DONE, capture preset into count and go to IDLE; load in RUN ignored.
REQ-017 SHALL clamp any preset digit >9 to 9 on capture.
REQ-018 SHALL give load priority over start_pause when both asserted in the same cycle.
REQ-019 SHALL on start_pause: IDLE->RUN if count nonzero (ignored if zero); RUN->PAUSE; PAUSE->RUN; ignored in DONE.
REQ-020 SHALL run a prescaler 0..TICK_DIV-1 only in RUN; tick asserts in the cycle prescaler equals TICK_DIV-1, then prescaler wraps to 0.
REQ-021 SHALL hold prescaler value in PAUSE (resume mid-period) and clear it to 0 in IDLE and DONE.
REQ-022 SHALL decrement count by 1 on each tick, BCD borrow chain: digit 0 borrows -> 9 and decrements next digit.
REQ-023 SHALL enter DONE in the cycle after the tick that makes count all-zero; count never wraps below zero.
REQ-024 SHALL keep count and outputs unchanged in PAUSE.
REQ-025 SHALL run scan counter in all states: scan index advances every SCAN_DIV cycles, wraps from NUM_DIGITS-1 to 0.
REQ-026 SHALL drive ssd_ctl[i]=0 only for i == scan index; ssd_in = count digit i; both registered-consistent (same cycle).

Reset
REQ-027 SHALL on rst: state=IDLE, count=0, prescaler=0, scan index=0, done=0, led=0, ssd_ctl with bit 0 low and others high, ssd_in=0.
REQ-028 SHALL honour rst asserted mid-RUN immediately (asynchronous), discarding partial tick.
REQ-029 SHALL leave IDLE only on explicit load/start_pause after rst release.

Configuration
REQ-030 SHALL support macro TIMER_AUTO_RELOAD_EN.
REQ-031 SHALL, with TIMER_AUTO_RELOAD_EN defined, on reaching zero, spend exactly one cycle in DONE (done/led pulse one cycle), then reload the last-captured preset and return to RUN with prescaler 0; if last preset was zero, stay in DONE.
REQ-032 SHALL, without TIMER_AUTO_RELOAD_EN, remain in DONE until load or rst.

Verification (NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=3)
REQ-033 SHALL cover: preset=0x12, load, start_pause -> bcd_out 12,11,10,09,...,00 every 4 cycles; DONE, led=0xFFFF after 00.
REQ-034 SHALL cover: start_pause at count 05 mid-period, wait 20 cycles, start_pause -> count stays 05, next decrement after remaining prescaler cycles.
REQ-035 SHALL cover: load+start_pause same cycle in PAUSE with preset=0x30 -> state IDLE, bcd_out 30; start_pause in IDLE with count 00 -> stays IDLE.
REQ-036 SHALL cover: preset=0xAF loaded -> bcd_out 99; rst pulse during RUN -> all outputs at reset values same cycle.
REQ-037 SHALL cover: scan -> ssd_ctl 10,01,10 changing every 3 cycles, ssd_in tracking digit 0/1.
REQ-038 SHALL cover with TIMER_AUTO_RELOAD_EN: preset=0x02 -> 02,01,00, one-cycle done, 02 reloaded, RUN continues.
